spart_rx: RTL and testbench
===========================

SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of rxd synchronizer flops (legal values 2..3).
REQ-002 The block SHALL have input clk, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have input rxd, 1 bit: the asynchronous serial line, idle high.
REQ-005 The block SHALL have input divisor, 16 bits: clk cycles per bit period, taken from the SPART divisor buffer.
REQ-006 The block SHALL have input rd_ack, 1 bit: a one-cycle pulse meaning the host has read the receive buffer (iocs & iorw & ioaddr==00).
REQ-007 The block SHALL have output rx_data, 8 bits: the last complete received byte.
REQ-008 The block SHALL have output rda, 1 bit: received data available.
REQ-009 The block SHALL have output shift, 1 bit: a one-cycle pulse at each bit sample point.
REQ-010 The block SHALL have output busy, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 rxd SHALL pass through SYNC_STAGES flops, reset to 1; all further logic SHALL use only the synchronized value rxs.
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-013 IDLE to START SHALL occur on a cycle where rxs==0 and the prior rxs==1; on that transition div_q SHALL latch max(divisor,1) and the bit counter SHALL load div_q>>1 (minimum 1).
REQ-014 The bit counter SHALL decrement each cycle; its expiry (counter==1) SHALL be the sample point, assert shift for that one cycle, and reload div_q.
REQ-015 At the START sample point, rxs==0 SHALL go to DATA; rxs==1 SHALL be a false start and return to IDLE with no output change.
REQ-016 In DATA, each sample point SHALL shift rxs into bit 7 of the shift register, shifting right, so the first data bit ends in bit 0 (LSB first).
REQ-017 DATA SHALL take 8 sample points, counted by a 3-bit index; on index wrap from 7 the FSM SHALL go to STOP.
REQ-018 At the STOP sample point with rxs==1, rx_data SHALL load the shift register and rda SHALL be 1 the following cycle.
REQ-019 At the STOP sample point with rxs==0 (framing error), the byte SHALL be discarded and rx_data and rda SHALL stay unchanged.
REQ-020 From the STOP sample point the FSM SHALL return to IDLE in the same cycle; a new start edge SHALL be accepted from the next cycle.
REQ-021 rd_ack SHALL clear rda on the next cycle; if rd_ack coincides with a new byte load, rda SHALL remain 1 and rx_data SHALL take the new byte.
REQ-022 A divisor change mid-frame SHALL not affect the current frame (div_q is used); the new value SHALL apply from the next start edge.
REQ-023 Divisor 0 SHALL behave as divisor 1.
REQ-024 Latency from the synchronized start edge to rda=1 SHALL be (div_q>>1) + 9*div_q + 1 clk cycles.

Reset
REQ-025 While rst==0, regardless of clk: state=IDLE, counters=0, shift register=0, rx_data=8'h00, rda=0, shift=0, busy=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no partial byte delivered.
REQ-027 After reset release, the first start edge SHALL be detected only after rxs has been 1 for at least one cycle.

Configuration
REQ-028 Macro SPART_RX_OVERRUN_EN defined: the block SHALL add output overrun (1 bit).
REQ-029 overrun SHALL be set when a valid byte loads while rda==1 and rd_ack==0, and cleared by rd_ack.
REQ-030 In an overrun the new byte SHALL still overwrite rx_data.
REQ-031 Macro SPART_RX_OVERRUN_EN undefined: the overrun port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package spart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, STOP), the ioaddr constants (ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11) and the DIV_W=16 constant.
REQ-033 Sub-module spart_sync (a parameterized N-flop synchronizer with reset value 1) SHALL implement the rxd synchronizer; no other sub-modules.

Verification
REQ-034 divisor=16; send 0x48 LSB first with a 16-cycle bit time -> rx_data=8'h48, rda=1 at 153 cycles after the synced start edge, and exactly 9 shift pulses.
REQ-035 divisor=16; drive a 4-cycle low glitch -> false start, FSM back in IDLE, rda=0, rx_data unchanged.
REQ-036 divisor=16; send 0x55 with stop bit forced 0 -> rda stays 0, rx_data keeps its prior value; a following 0xA3 is received correctly.
REQ-037 divisor=16; send 0x27 then 0x3C without rd_ack -> rx_data=8'h3C, rda=1, overrun=1 (with SPART_RX_OVERRUN_EN); a rd_ack pulse -> rda=0, overrun=0.
REQ-038 Change divisor 16->32 during the DATA bits of 0x81 -> 0x81 received at 16-cycle timing; the next byte 0x7E is received at 32-cycle timing.
REQ-039 Assert rst during bit 4 of 0xF0 -> all outputs at reset values immediately; after release, a frame 0x0F -> rx_data=8'h0F.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive path.
package spart_pkg;

   localparam int DIV_W = 16;

   localparam logic [1:0] ADDR_BUF  = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // A zero divisor would never let the bit counter expire, so treat it as 1.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   function automatic logic [DIV_W-1:0] half_div(input logic [DIV_W-1:0] d);
      logic [DIV_W-1:0] h;
      h = d >> 1;
      return (h == '0) ? DIV_W'(1) : h;
   endfunction

endpackage

// File: rtl/spart_sync.sv
// N-flop synchronizer for an idle-high asynchronous line; every stage resets to 1.
module spart_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] sync_q;
   logic [N-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[N-2:0], d};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '1;
      else      sync_q <= sync_d;
   end

   assign q = sync_q[N-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserializer sampling mid-bit from a programmable divisor.
// Optional macro SPART_RX_OVERRUN_EN adds the overrun status output.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit; deliver byte only if it is high
module spart_rx
   import spart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rxd,
   input  logic [DIV_W-1:0] divisor,
   input  logic             rd_ack,
   output logic [7:0]       rx_data,
   output logic             rda,
   output logic             shift,
   output logic             busy
`ifdef SPART_RX_OVERRUN_EN
   ,
   output logic             overrun
`endif
);

   logic rxs;

   spart_sync #(.N(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxs)
   );

   rx_state_t        state_q, state_d;
   logic             rxs_prev_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rda_q, rda_d;
   logic             shift_q, shift_d;
   logic             busy_q, busy_d;
   logic             sample;
   logic             load;
`ifdef SPART_RX_OVERRUN_EN
   logic             overrun_q, overrun_d;
`endif

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      rx_data_d = rx_data_q;
      shift_d   = 1'b0;
      load      = 1'b0;
      sample    = (cnt_q == DIV_W'(1));

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs && rxs_prev_q) begin
               state_d = START;
               div_d   = eff_div(divisor);
               cnt_d   = half_div(eff_div(divisor));
            end
         end
         START: begin
            cnt_d = cnt_q - 1'b1;
            if (sample) begin
               cnt_d = div_q;
               if (!rxs) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         DATA: begin
            cnt_d = cnt_q - 1'b1;
            if (sample) begin
               cnt_d   = div_q;
               shreg_d = {rxs, shreg_q[7:1]};
               idx_d   = idx_q + 1'b1;
               shift_d = 1'b1;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            cnt_d = cnt_q - 1'b1;
            if (sample) begin
               shift_d = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
               if (rxs) begin
                  rx_data_d = shreg_q;
                  load      = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // A byte landing in the same cycle as a read keeps data available.
      rda_d  = load | (rda_q & ~rd_ack);
      busy_d = (state_d != IDLE);

`ifdef SPART_RX_OVERRUN_EN
      overrun_d = overrun_q;
      if (load && rda_q && !rd_ack) overrun_d = 1'b1;
      else if (rd_ack)              overrun_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rxs_prev_q <= 1'b1;
         div_q      <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         shreg_q    <= '0;
         rx_data_q  <= '0;
         rda_q      <= 1'b0;
         shift_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef SPART_RX_OVERRUN_EN
         overrun_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rxs_prev_q <= rxs;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shreg_q    <= shreg_d;
         rx_data_q  <= rx_data_d;
         rda_q      <= rda_d;
         shift_q    <= shift_d;
         busy_q     <= busy_d;
`ifdef SPART_RX_OVERRUN_EN
         overrun_q  <= overrun_d;
`endif
      end
   end

   assign rx_data = rx_data_q;
   assign rda     = rda_q;
   assign shift   = shift_q;
   assign busy    = busy_q;
`ifdef SPART_RX_OVERRUN_EN
   assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: vector table, timed corner sequences, random frames vs. a byte-level model.
// Overrun checks are compiled in when SPART_RX_OVERRUN_EN is defined.
module tb_spart_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rxd = 1'b1;
   logic        rd_ack = 1'b0;
   logic [15:0] divisor = 16'd16;
   logic [7:0]  rx_data;
   logic        rda;
   logic        shift;
   logic        busy;
`ifdef SPART_RX_OVERRUN_EN
   logic        overrun;
`endif

   spart_rx dut (
      .clk     (clk),
      .rst     (rst),
      .rxd     (rxd),
      .divisor (divisor),
      .rd_ack  (rd_ack),
      .rx_data (rx_data),
      .rda     (rda),
      .shift   (shift),
      .busy    (busy)
`ifdef SPART_RX_OVERRUN_EN
      ,
      .overrun (overrun)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int shift_total = 0;
   int lat;
   int s0;

   // Reference model state: what a host should see, updated per frame/ack.
   logic [7:0] exp_data;
   bit         exp_rda;
   bit         exp_ovr;

   always @(negedge clk) if (shift === 1'b1) shift_total++;

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      int         bt;
      bit         ack_before;
      logic [7:0] exp_data;
      bit         exp_rda;
      bit         exp_ovr;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_ack();
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bt, input int start_bt);
      rxd = 1'b0;
      repeat (start_bt) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (bt) @(negedge clk);
      end
      rxd = stop_ok;
      repeat (bt) @(negedge clk);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Negedges from driving the start bit until rda is seen high.
   task automatic measure_rda();
      lat = 0;
      while (rda !== 1'b1 && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Expected rda latency seen from the bench: (D>>1 min 1) + 9*D + 1 after the
   // synchronized edge, plus two synchronizer stages.
   function automatic int exp_latency(input int d);
      int h;
      h = d / 2;
      if (h == 0) h = 1;
      return h + 9 * d + 1 + 2;
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h55, 1'b0, 16, 1'b1, 8'h48, 1'b0, 1'b0};
      vecs[1] = '{8'hA3, 1'b1, 16, 1'b0, 8'hA3, 1'b1, 1'b0};
      vecs[2] = '{8'h27, 1'b1, 16, 1'b1, 8'h27, 1'b1, 1'b0};
      vecs[3] = '{8'h3C, 1'b1, 16, 1'b0, 8'h3C, 1'b1, 1'b1};
      vecs[4] = '{8'h00, 1'b1,  8, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 1'b0,  8, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'hC5, 1'b1, 11, 1'b0, 8'hC5, 1'b1, 1'b0};
      vecs[7] = '{8'h6A, 1'b1,  3, 1'b0, 8'h6A, 1'b1, 1'b1};
      vecs[8] = '{8'h4D, 1'b1,  2, 1'b1, 8'h4D, 1'b1, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rda", 32'(rda), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_shift", 32'(shift), 32'd0);
`ifdef SPART_RX_OVERRUN_EN
      check("reset_overrun", 32'(overrun), 32'd0);
`endif
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // 0x48 at divisor 16: latency and shift pulse count
      divisor = 16'd16;
      s0 = shift_total;
      fork
         send_frame(8'h48, 1'b1, 16, 16);
         measure_rda();
      join
      check("lat_48", 32'(lat), 32'(exp_latency(16)));
      check("data_48", 32'(rx_data), 32'h48);
      check("rda_48", 32'(rda), 32'd1);
      check("shifts_48", 32'(shift_total - s0), 32'd9);

      // Vector table
      for (int i = 0; i < 9; i++) begin
         divisor = 16'(vecs[i].bt);
         if (vecs[i].ack_before) pulse_ack();
         send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].bt, vecs[i].bt);
         check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_rda", i), 32'(rda), 32'(vecs[i].exp_rda));
`ifdef SPART_RX_OVERRUN_EN
         check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
`endif
      end
      pulse_ack();
      check("ack_clears_rda", 32'(rda), 32'd0);
`ifdef SPART_RX_OVERRUN_EN
      check("ack_clears_ovr", 32'(overrun), 32'd0);
`endif

      // Glitch shorter than half a bit is a false start
      divisor = 16'd16;
      s0 = shift_total;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      @(negedge clk);
      check("glitch_busy_seen", 32'(busy), 32'd1);
      repeat (15) @(negedge clk);
      check("glitch_back_idle", 32'(busy), 32'd0);
      check("glitch_rda", 32'(rda), 32'd0);
      check("glitch_data", 32'(rx_data), 32'h4D);
      check("glitch_shifts", 32'(shift_total - s0), 32'd0);

      // Divisor change mid-frame applies only from the next start edge
      fork
         send_frame(8'h81, 1'b1, 16, 16);
         measure_rda();
         begin
            repeat (40) @(negedge clk);
            divisor = 16'd32;
         end
      join
      check("divchg_lat_81", 32'(lat), 32'(exp_latency(16)));
      check("divchg_data_81", 32'(rx_data), 32'h81);
      pulse_ack();
      fork
         send_frame(8'h7E, 1'b1, 32, 32);
         measure_rda();
      join
      check("divchg_lat_7E", 32'(lat), 32'(exp_latency(32)));
      check("divchg_data_7E", 32'(rx_data), 32'h7E);

      // rd_ack in the very cycle a new byte loads: rda stays, byte replaced
      divisor = 16'd16;
      fork
         send_frame(8'h99, 1'b1, 16, 16);
         begin
            repeat (exp_latency(16) - 1) @(negedge clk);
            rd_ack = 1'b1;
            @(negedge clk);
            rd_ack = 1'b0;
         end
      join
      check("coinc_data", 32'(rx_data), 32'h99);
      check("coinc_rda", 32'(rda), 32'd1);
`ifdef SPART_RX_OVERRUN_EN
      check("coinc_ovr", 32'(overrun), 32'd0);
`endif
      pulse_ack();

      // Divisor 0 behaves as divisor 1 (start bit held 2 cycles to line up)
      divisor = 16'd0;
      send_frame(8'h5A, 1'b1, 1, 2);
      check("div0_data", 32'(rx_data), 32'h5A);
      check("div0_rda", 32'(rda), 32'd1);
      pulse_ack();
      divisor = 16'd1;
      send_frame(8'hA5, 1'b1, 1, 2);
      check("div1_data", 32'(rx_data), 32'hA5);

      // Reset during bit 4 of 0xF0
      divisor = 16'd16;
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (8) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rstmid_data", 32'(rx_data), 32'h00);
      check("rstmid_rda", 32'(rda), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_shift", 32'(shift), 32'd0);
      @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("rstrel_busy", 32'(busy), 32'd0);
      check("rstrel_rda", 32'(rda), 32'd0);
      send_frame(8'h0F, 1'b1, 16, 16);
      check("rstrel_data", 32'(rx_data), 32'h0F);
      check("rstrel_rda1", 32'(rda), 32'd1);

      // Random frames against the byte-level model
      exp_data = 8'h0F;
      exp_rda  = 1'b1;
      exp_ovr  = 1'b0;
      for (int n = 0; n < 24; n++) begin
         int         bt;
         logic [7:0] b;
         bit         ok;
         case ($urandom_range(0, 3))
            0:       bt = 4;
            1:       bt = 7;
            2:       bt = 16;
            default: bt = 23;
         endcase
         divisor = 16'(bt);
         if ($urandom_range(0, 2) == 0) begin
            pulse_ack();
            exp_rda = 1'b0;
            exp_ovr = 1'b0;
         end
         b  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         send_frame(b, ok, bt, bt);
         if (ok) begin
            if (exp_rda) exp_ovr = 1'b1;
            exp_data = b;
            exp_rda  = 1'b1;
         end
         check($sformatf("rand%0d_data", n), 32'(rx_data), 32'(exp_data));
         check($sformatf("rand%0d_rda", n), 32'(rda), 32'(exp_rda));
`ifdef SPART_RX_OVERRUN_EN
         check($sformatf("rand%0d_ovr", n), 32'(overrun), 32'(exp_ovr));
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
